crc_stream_engine: RTL and testbench

CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

---
 rtl/crc_pkg.sv | 16 +
 rtl/crc_next.sv | 26 ++
 rtl/crc_stream_engine.sv | 89 ++++++++
 tb/tb_crc_stream_engine.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC stream engine.
package crc_pkg;

    // Frame-level FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } crc_state_t;

    // Common generator polynomials (implicit top term omitted).
    localparam logic [15:0] CRC16_8005  = 16'h8005;
    localparam logic [15:0] CRC16_CCITT = 16'h1021;
    localparam logic [31:0] CRC32       = 32'h04C11DB7;

endpackage

// File: rtl/crc_next.sv
// Combinational CRC update over one DW-bit word, processed MSB-first.
module crc_next #(
    parameter int             DW   = 16,
    parameter int             CW   = 16,
    parameter logic [CW-1:0]  POLY = 16'h8005
) (
    input  logic [CW-1:0] crc_in,
    input  logic [DW-1:0] data,
    output logic [CW-1:0] crc_out
);

    logic [CW-1:0] c;
    logic          fb;

    // Unrolled bit-serial shift/xor, one iteration per data bit.
    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int unsigned i = 0; i < DW; i++) begin
            fb = c[CW-1] ^ data[DW-1-i];
            c  = {c[CW-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: frames delimited by sof/eof, one result strobe per
// completed frame. Optional received-CRC comparison under CRC_CHECK_EN.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int             DW     = 16,
    parameter int             CW     = 16,
    parameter logic [CW-1:0]  POLY   = 16'h8005,
    parameter logic [CW-1:0]  INIT   = '0,
    parameter logic [CW-1:0]  XOROUT = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_sof,
    input  logic          in_eof,
`ifdef CRC_CHECK_EN
    input  logic [CW-1:0] chk_crc,
    output logic          crc_err,
`endif
    output logic          out_valid,
    output logic [CW-1:0] out_crc,
    output logic          busy
);

    crc_state_t    state, state_nxt;
    logic [CW-1:0] crc_q;
    logic [CW-1:0] seed;
    logic [CW-1:0] crc_step;
    logic          accept;
    logic          load;

    assign in_ready  = (state != OUT);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign accept    = in_valid & in_ready;
    // Non-sof beats only advance the CRC inside an open frame.
    assign load      = accept & (in_sof | (state == CALC));
    assign seed      = in_sof ? INIT : crc_q;

    crc_next #(
        .DW   (DW),
        .CW   (CW),
        .POLY (POLY)
    ) u_next (
        .crc_in  (seed),
        .data    (in_data),
        .crc_out (crc_step)
    );

    // Next-state logic for frame tracking.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept && in_sof) state_nxt = in_eof ? OUT : CALC;
            CALC: if (accept && in_eof) state_nxt = OUT;
            OUT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, running CRC and result register; the result is captured at
    // the eof edge so it already equals crc ^ XOROUT during OUT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            crc_q   <= INIT;
            out_crc <= '0;
        end else begin
            state <= state_nxt;
            if (load) crc_q <= crc_step;
            if (load && in_eof) out_crc <= crc_step ^ XOROUT;
        end
    end

`ifdef CRC_CHECK_EN
    // Compare the final CRC against the sampled reference on the eof beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            crc_err <= 1'b0;
        end else if (load && in_eof) begin
            crc_err <= ((crc_step ^ XOROUT) != chk_crc);
        end
    end
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed self-checking bench for crc_stream_engine. Three instances share
// control inputs (their FSMs therefore track identically); define
// CRC_CHECK_EN to also exercise the comparator.
module tb_crc_stream_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_sof;
    logic        in_eof;
    logic [15:0] d16;
    logic [7:0]  d8;
    logic [15:0] chk;

    logic        rdy16, ov16, busy16;
    logic [15:0] oc16;
    logic        rdy8, ov8, busy8;
    logic [15:0] oc8;
    logic        rdy8c, ov8c, busy8c;
    logic [15:0] oc8c;
`ifdef CRC_CHECK_EN
    logic        err16, err8, err8c;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int pulses16 = 0;
    int pulses8  = 0;
    int p0;

    assign d8 = d16[7:0];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ov16) pulses16 <= pulses16 + 1;
        if (ov8)  pulses8  <= pulses8 + 1;
    end

    crc_stream_engine #(.DW(16)) u16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy16),
        .in_data(d16), .in_sof(in_sof), .in_eof(in_eof),
`ifdef CRC_CHECK_EN
        .chk_crc(chk), .crc_err(err16),
`endif
        .out_valid(ov16), .out_crc(oc16), .busy(busy16)
    );

    crc_stream_engine #(.DW(8)) u8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy8),
        .in_data(d8), .in_sof(in_sof), .in_eof(in_eof),
`ifdef CRC_CHECK_EN
        .chk_crc(chk), .crc_err(err8),
`endif
        .out_valid(ov8), .out_crc(oc8), .busy(busy8)
    );

    crc_stream_engine #(
        .DW   (8),
        .POLY (crc_pkg::CRC16_CCITT),
        .INIT (16'hFFFF)
    ) u8c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy8c),
        .in_data(d8), .in_sof(in_sof), .in_eof(in_eof),
`ifdef CRC_CHECK_EN
        .chk_crc(chk), .crc_err(err8c),
`endif
        .out_valid(ov8c), .out_crc(oc8c), .busy(busy8c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Optional idle gap (with junk data), then one beat held until accepted.
    task automatic beat(input logic [15:0] d, input logic s, input logic e,
                        input int gap);
        int n;
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            d16 = 16'($urandom);
            tick();
        end
        in_valid = 1'b1;
        d16      = d;
        in_sof   = s;
        in_eof   = e;
        n = 0;
        while (!rdy16 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) check_eq("ready_timeout", 32'(rdy16), 32'd1);
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
    endtask

    // "123456789" as nine byte beats.
    task automatic send_digits(input int max_gap);
        for (int i = 0; i < 9; i++)
            beat(16'h0031 + 16'(i), i == 0, i == 8,
                 (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        d16      = '0;
        chk      = '0;
        tick();
        tick();

        // Reset state
        check_eq("rst_out_valid", 32'(ov16), 32'd0);
        check_eq("rst_out_crc",   32'(oc16), 32'd0);
        check_eq("rst_busy",      32'(busy16), 32'd0);
        check_eq("rst_in_ready",  32'(rdy16), 32'd1);
        reset = 1'b1;
        tick();

        // One-word frame, DW=16
        beat(16'h0001, 1'b1, 1'b1, 0);
        check_eq("one_word_valid", 32'(ov16), 32'd1);
        check_eq("one_word_crc",   32'(oc16), 32'h8005);
        check_eq("one_word_ready", 32'(rdy16), 32'd0);
        tick();
        check_eq("one_word_pulse_end", 32'(ov16), 32'd0);
        check_eq("one_word_hold",      32'(oc16), 32'h8005);
        check_eq("one_word_idle",      32'(busy16), 32'd0);

        // CRC-16/UMTS check string, no gaps
        send_digits(0);
        check_eq("umts_valid", 32'(ov8), 32'd1);
        check_eq("umts_crc",   32'(oc8), 32'hFEE8);
        tick();

        // CRC-16/CCITT-FALSE check string with random stalls
        send_digits(3);
        check_eq("ccitt_valid", 32'(ov8c), 32'd1);
        check_eq("ccitt_crc",   32'(oc8c), 32'h29B1);
        check_eq("ccitt_ready_out", 32'(rdy8c), 32'd0);
        tick();
        tick();
        check_eq("ccitt_hold", 32'(oc8c), 32'h29B1);

        // Stray beats in IDLE, abandoned frame, then one-word frame
        p0 = pulses16;
        beat(16'hFFFF, 1'b0, 1'b0, 0);
        check_eq("idle_stray_busy", 32'(busy16), 32'd0);
        beat(16'hAAAA, 1'b0, 1'b1, 0);
        check_eq("idle_stray_eof_busy", 32'(busy16), 32'd0);
        check_eq("idle_stray_eof_valid", 32'(ov16), 32'd0);
        beat(16'h1234, 1'b1, 1'b0, 0);
        beat(16'h5678, 1'b0, 1'b0, 1);
        beat(16'h9ABC, 1'b0, 1'b0, 0);
        check_eq("abandon_busy", 32'(busy16), 32'd1);
        beat(16'h0001, 1'b1, 1'b1, 0);
        check_eq("restart_valid", 32'(ov16), 32'd1);
        check_eq("restart_crc",   32'(oc16), 32'h8005);
        tick();
        check_eq("restart_single_pulse", 32'(pulses16), 32'(p0 + 1));

        // Reset during CALC
        beat(16'h0031, 1'b1, 1'b0, 0);
        check_eq("pre_reset_busy", 32'(busy8), 32'd1);
        p0 = pulses8;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_eq("mid_reset_valid", 32'(ov8), 32'd0);
        check_eq("mid_reset_crc",   32'(oc8), 32'd0);
        check_eq("mid_reset_busy",  32'(busy8), 32'd0);
        check_eq("mid_reset_ready", 32'(rdy8), 32'd1);
        beat(16'h0039, 1'b0, 1'b1, 0);
        tick();
        check_eq("mid_reset_no_pulse", 32'(pulses8), 32'(p0));
        send_digits(0);
        check_eq("post_reset_crc", 32'(oc8), 32'hFEE8);
        tick();

`ifdef CRC_CHECK_EN
        // Comparator: matching and mismatching reference
        chk = 16'hFEE8;
        send_digits(0);
        check_eq("chk_match_err", 32'(err8), 32'd0);
        tick();
        chk = 16'hFEE9;
        send_digits(0);
        check_eq("chk_bad_err", 32'(err8), 32'd1);
        tick();
        tick();
        check_eq("chk_bad_hold", 32'(err8), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
